alu_decode_stage: RTL

- Single-entry pipelined decode stage that feeds the integer unit.
- Accepts 32-bit RV32I instruction words from fetch over a valid/ready handshake and decodes the ALU-class opcodes: OP (0110011), OP-IMM (0010011) and LUI (0110111).
- Registers the result: register-file addresses, immediate, immediate select, ALU operation code, write-enable and an illegal flag, presented to execute over a second valid/ready handshake.
- Sits between fetch and the integer unit; the register file is read combinationally from the registered rs1/rs2 addresses.

---
 rtl/alu_decode_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Single-entry pipelined decode stage between fetch and the integer unit.
//   Decodes the RV32I ALU-class opcodes (OP, OP-IMM, LUI) into register
//   addresses, immediate, operand select, ALU op code, write enable and an
//   illegal flag, and holds the result in one output register slot.
//
// Ports
//   clk, rstn          clock; synchronous active-low reset
//   i_flush            drop the held entry (and any instruction offered)
//   i_if_valid/o_if_ready/i_if_instr   fetch-side handshake and instruction
//   o_id_valid/i_ex_ready               execute-side handshake
//   o_id_rs1_addr, o_id_rs2_addr, o_id_rd_addr, o_id_rd_wen
//   o_id_imm, o_id_imm_sel, o_id_op_data, o_id_illegal  decoded fields
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_flush,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    output logic            o_id_valid,
    input  logic            i_ex_ready,
    output logic [4:0]      o_id_rs1_addr,
    output logic [4:0]      o_id_rs2_addr,
    output logic [4:0]      o_id_rd_addr,
    output logic            o_id_rd_wen,
    output logic [XLEN-1:0] o_id_imm,
    output logic            o_id_imm_sel,
    output logic [3:0]      o_id_op_data,
    output logic            o_id_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // funct3 -> op for the funct7 = 0 encodings, shared by OP and OP-IMM
    function automatic alu_op_e base_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_imm;
    logic            dec_imm_sel, dec_legal, dec_wen;

    logic            valid_q, valid_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            rd_wen_q, rd_wen_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            imm_sel_q, imm_sel_d;
    logic [3:0]      op_q, op_d;
    logic            illegal_q, illegal_d;

    assign opcode = i_if_instr[6:0];
    assign funct3 = i_if_instr[14:12];
    assign funct7 = i_if_instr[31:25];

    // Combinational decode of the instruction on the fetch port. Anything
    // not recognised falls out as illegal with a neutral Add/no-immediate
    // payload so execute can treat it as an ordinary (harmless) entry.
    always_comb begin
        dec_rs1     = i_if_instr[19:15];
        dec_rs2     = i_if_instr[24:20];
        dec_rd      = i_if_instr[11:7];
        dec_op      = ALU_ADD;
        dec_imm     = '0;
        dec_imm_sel = 1'b0;
        dec_legal   = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    dec_op    = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                dec_imm_sel = 1'b1;
                // Shifts carry a 5-bit shamt; the funct7 bits above it are
                // an encoding field and must not reach the immediate.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_imm = XLEN'(i_if_instr[24:20]);
                    if (funct7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = base_op(funct3);
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_op    = ALU_SRA;
                    end
                end else begin
                    dec_legal = 1'b1;
                    dec_op    = base_op(funct3);
                    dec_imm   = XLEN'($signed(i_if_instr[31:20]));
                end
            end
            OPC_LUI: begin
                // x0 + imm through the adder
                dec_legal   = 1'b1;
                dec_rs1     = 5'd0;
                dec_imm_sel = 1'b1;
                dec_imm     = XLEN'($signed({i_if_instr[31:12], 12'b0}));
            end
            default: ;
        endcase

        if (!dec_legal) begin
            dec_op      = ALU_ADD;
            dec_imm     = '0;
            dec_imm_sel = 1'b0;
        end
        dec_wen = dec_legal && (dec_rd != 5'd0);
    end

    // The slot frees up whenever it is empty or being drained this cycle.
    assign o_if_ready = !valid_q || i_ex_ready;

    // Next-state for the output slot: flush beats accept, accept beats drain,
    // otherwise everything holds so execute sees stable fields under stall.
    always_comb begin
        valid_d   = valid_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        imm_d     = imm_q;
        imm_sel_d = imm_sel_q;
        op_d      = op_q;
        illegal_d = illegal_q;

        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_if_valid && o_if_ready) begin
            valid_d   = 1'b1;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            rd_wen_d  = dec_wen;
            imm_d     = dec_imm;
            imm_sel_d = dec_imm_sel;
            op_d      = dec_op;
            illegal_d = !dec_legal;
        end else if (i_ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output slot register; reset clears every field, not just valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_id_valid    = valid_q;
    assign o_id_rs1_addr = rs1_q;
    assign o_id_rs2_addr = rs2_q;
    assign o_id_rd_addr  = rd_q;
    assign o_id_rd_wen   = rd_wen_q;
    assign o_id_imm      = imm_q;
    assign o_id_imm_sel  = imm_sel_q;
    assign o_id_op_data  = op_q;
    assign o_id_illegal  = illegal_q;

endmodule
